// File: rtl/if_id_inst_queue.sv
// DEPTH-entry instruction queue between fetch and decode, with flush, an exception fence and occupancy count.
// Optional zero-latency empty-queue bypass when IF_ID_QUEUE_BYPASS_EN is defined.
module if_id_inst_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 40,
  parameter int INST_W  = 32,
  parameter int CAUSE_W = 6,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               push_valid_i,
  output logic               push_ready_o,
  input  logic [PC_W-1:0]    push_pc_i,
  input  logic [INST_W-1:0]  push_inst_i,
  input  logic               push_xcpt_valid_i,
  input  logic [CAUSE_W-1:0] push_xcpt_cause_i,
  input  logic               push_pred_taken_i,
  input  logic [PC_W-1:0]    push_pred_addr_i,
  output logic               pop_valid_o,
  input  logic               pop_ready_i,
  output logic [PC_W-1:0]    pop_pc_o,
  output logic [INST_W-1:0]  pop_inst_o,
  output logic               pop_xcpt_valid_o,
  output logic [CAUSE_W-1:0] pop_xcpt_cause_o,
  output logic               pop_pred_taken_o,
  output logic [PC_W-1:0]    pop_pred_addr_o,
  output logic [PTR_W:0]     count_o
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INST_W-1:0]  inst;
    logic               xcpt_valid;
    logic [CAUSE_W-1:0] xcpt_cause;
    logic               pred_taken;
    logic [PC_W-1:0]    pred_addr;
  } entry_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  entry_t           push_ent;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fence;
  logic             empty;
  logic             bypass;
  logic             push_fire;
  logic             wr_en;
  logic             rd_en;

  assign push_ent = {push_pc_i, push_inst_i, push_xcpt_valid_i, push_xcpt_cause_i,
                     push_pred_taken_i, push_pred_addr_i};

  assign empty        = (count == '0);
  assign push_ready_o = (count < CNT_FULL) && !fence;
  assign push_fire    = push_valid_i && push_ready_o;

`ifdef IF_ID_QUEUE_BYPASS_EN
  // Empty queue and a ready decoder: hand the fetch entry straight through without storing it.
  assign bypass = empty && push_valid_i && pop_ready_i && !fence && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign wr_en = push_fire && !bypass;
  assign rd_en = !empty && pop_ready_i;

  assign pop_valid_o = !empty || bypass;

  // Data fields read as zero when nothing is presented, so stale storage never leaks out.
  always_comb begin
    head = '0;
    if (bypass)      head = push_ent;
    else if (!empty) head = mem[rd_ptr];
  end

  assign pop_pc_o         = head.pc;
  assign pop_inst_o       = head.inst;
  assign pop_xcpt_valid_o = head.xcpt_valid;
  assign pop_xcpt_cause_o = head.xcpt_cause;
  assign pop_pred_taken_o = head.pred_taken;
  assign pop_pred_addr_o  = head.pred_addr;
  assign count_o          = count;

  always_ff @(posedge clk_i) begin
    if (wr_en && rstn_i && !flush_i) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fence  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Nothing younger than a faulting fetch may enter until the pipeline is redirected.
      if (push_fire && push_xcpt_valid_i) fence <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Scoreboard bench for if_id_inst_queue: directed pushes queue expected entries, a negedge monitor checks pops.
module tb_if_id_inst_queue;
  logic        clk_i = 1'b0;
  logic        rstn_i, flush_i;
  logic        push_valid_i, push_ready_o;
  logic [39:0] push_pc_i, push_pred_addr_i;
  logic [31:0] push_inst_i;
  logic        push_xcpt_valid_i, push_pred_taken_i;
  logic [5:0]  push_xcpt_cause_i;
  logic        pop_valid_o, pop_ready_i;
  logic [39:0] pop_pc_o, pop_pred_addr_o;
  logic [31:0] pop_inst_o;
  logic        pop_xcpt_valid_o, pop_pred_taken_o;
  logic [5:0]  pop_xcpt_cause_o;
  logic [2:0]  count_o;

  typedef struct {
    logic [39:0] pc;
    logic [31:0] inst;
    logic        xv;
    logic [5:0]  cause;
    logic        pt;
    logic [39:0] pa;
  } ent_t;

  ent_t sb[$];
  int total = 0;
  int bad   = 0;

  if_id_inst_queue dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_pc_i(push_pc_i), .push_inst_i(push_inst_i),
    .push_xcpt_valid_i(push_xcpt_valid_i), .push_xcpt_cause_i(push_xcpt_cause_i),
    .push_pred_taken_i(push_pred_taken_i), .push_pred_addr_i(push_pred_addr_i),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
    .pop_pc_o(pop_pc_o), .pop_inst_o(pop_inst_o),
    .pop_xcpt_valid_o(pop_xcpt_valid_o), .pop_xcpt_cause_o(pop_xcpt_cause_o),
    .pop_pred_taken_o(pop_pred_taken_o), .pop_pred_addr_o(pop_pred_addr_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [39:0] pc, input logic [31:0] inst,
                              input logic xv = 1'b0, input logic [5:0] cause = 6'd0);
    ent_t e;
    e.pc = pc; e.inst = inst; e.xv = xv; e.cause = cause;
    e.pt = pc[3]; e.pa = pc + 40'h100;
    return e;
  endfunction

  // Monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rstn_i && !flush_i && pop_valid_o && pop_ready_i) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_unexpected: got inst %0h expected no entry", pop_inst_o);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("pop_pc",    64'(pop_pc_o),         64'(e.pc));
        chk("pop_inst",  64'(pop_inst_o),       64'(e.inst));
        chk("pop_xv",    64'(pop_xcpt_valid_o), 64'(e.xv));
        chk("pop_cause", 64'(pop_xcpt_cause_o), 64'(e.cause));
        chk("pop_pt",    64'(pop_pred_taken_o), 64'(e.pt));
        chk("pop_pa",    64'(pop_pred_addr_o),  64'(e.pa));
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic drv(input ent_t e, input bit pv, input bit pr, input bit fl = 1'b0);
    push_valid_i = pv; pop_ready_i = pr; flush_i = fl;
    push_pc_i = e.pc; push_inst_i = e.inst; push_xcpt_valid_i = e.xv;
    push_xcpt_cause_i = e.cause; push_pred_taken_i = e.pt; push_pred_addr_i = e.pa;
  endtask

  task automatic idle(input bit pr = 1'b0);
    drv(mk(40'h0, 32'h0), 1'b0, pr);
  endtask

  // Push expected to be accepted this cycle.
  task automatic push(input ent_t e, input bit pr = 1'b0);
    drv(e, 1'b1, pr);
    sb.push_back(e);
  endtask

  ent_t fill [6];

  initial begin
    fill[0] = mk(40'h001000, 32'h00003013);
    fill[1] = mk(40'h001004, 32'h00500013);
    fill[2] = mk(40'h001008, 32'h00804013);
    fill[3] = mk(40'h00100c, 32'hfff02013);
    fill[4] = mk(40'h001010, 32'h00a00093);
    fill[5] = mk(40'h001014, 32'h00b00113);

    rstn_i = 1'b0; idle();
    tick(); tick();
    rstn_i = 1'b1;
    mid();
    chk("rst_pop_valid",  64'(pop_valid_o),  64'd0);
    chk("rst_push_ready", 64'(push_ready_o), 64'd1);
    chk("rst_count",      64'(count_o),      64'd0);
    chk("rst_pop_inst",   64'(pop_inst_o),   64'd0);
    chk("rst_pop_pc",     64'(pop_pc_o),     64'd0);

    // Single push, one-cycle latency.
    tick(); push(mk(40'h002010, 32'hfff02013));
    mid(); chk("single_same_cycle_valid", 64'(pop_valid_o), 64'd0);
    tick(); idle();
    mid();
    chk("single_valid", 64'(pop_valid_o), 64'd1);
    chk("single_inst",  64'(pop_inst_o),  64'hfff02013);
    chk("single_count", 64'(count_o),     64'd1);
    tick(); idle(1'b1);
    tick(); idle();
    mid(); chk("single_drained", 64'(count_o), 64'd0);

    // Fill to full, try an extra push, then wrap.
    for (int i = 0; i < 4; i++) begin tick(); push(fill[i]); end
    tick(); drv(mk(40'h00dead, 32'hdeadbeef), 1'b1, 1'b0);
    mid();
    chk("full_push_ready", 64'(push_ready_o), 64'd0);
    chk("full_count",      64'(count_o),      64'd4);
    tick(); idle(1'b1);
    mid(); chk("full_hold_count", 64'(count_o), 64'd4);
    tick(); idle(1'b1);
    tick(); push(fill[4]);
    mid(); chk("wrap_count2", 64'(count_o), 64'd2);
    tick(); push(fill[5]);
    tick(); idle();
    mid();
    chk("wrap_count4", 64'(count_o),      64'd4);
    chk("wrap_ready",  64'(push_ready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin tick(); idle(1'b1); end
    tick(); idle();
    mid(); chk("wrap_empty", 64'(count_o), 64'd0);

    // Simultaneous push and pop held at count 2.
    tick(); push(mk(40'h003000, 32'h10000013));
    tick(); push(mk(40'h003004, 32'h10100013));
    for (int i = 0; i < 5; i++) begin
      tick(); push(mk(40'h003008 + 40'(4*i), 32'h10200013 + 32'(i)), 1'b1);
      mid(); chk("simul_count", 64'(count_o), 64'd2);
    end
    tick(); idle(1'b1);
    mid(); chk("simul_after_count", 64'(count_o), 64'd2);
    tick(); idle(1'b1);
    tick(); idle();
    mid(); chk("simul_drained", 64'(count_o), 64'd0);

    // Exception fence.
    tick(); push(mk(40'h004000, 32'h00000073, 1'b1, 6'd1));
    mid(); chk("fence_ready_same_cycle", 64'(push_ready_o), 64'd1);
    tick(); drv(mk(40'h004004, 32'h00100013), 1'b1, 1'b0);
    mid();
    chk("fence_ready_drop", 64'(push_ready_o), 64'd0);
    chk("fence_count1",     64'(count_o),      64'd1);
    tick(); idle(1'b1);
    tick(); drv(mk(40'h004008, 32'h00200013), 1'b1, 1'b1);
    mid();
    chk("fence_drained",       64'(count_o),      64'd0);
    chk("fence_ready_hold",    64'(push_ready_o), 64'd0);
    chk("fence_no_bypass",     64'(pop_valid_o),  64'd0);
    tick(); drv(mk(40'h0, 32'h0), 1'b0, 1'b0, 1'b1);
    tick(); idle();
    mid(); chk("fence_cleared", 64'(push_ready_o), 64'd1);

    // Flush with a simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin tick(); push(fill[i]); end
    tick(); drv(mk(40'h005000, 32'h0badf00d), 1'b1, 1'b1, 1'b1);
    mid(); chk("flush_pre_count", 64'(count_o), 64'd3);
    tick(); sb.delete(); idle();
    mid();
    chk("flush_count", 64'(count_o),     64'd0);
    chk("flush_valid", 64'(pop_valid_o), 64'd0);
    chk("flush_inst",  64'(pop_inst_o),  64'd0);
    tick(); idle(1'b1);
    mid(); chk("flush_absent", 64'(pop_valid_o), 64'd0);

    // Empty-queue push with a ready decoder.
    tick(); push(mk(40'h006000, 32'h00500013), 1'b1);
    mid();
`ifdef IF_ID_QUEUE_BYPASS_EN
    chk("byp_valid", 64'(pop_valid_o), 64'd1);
    chk("byp_inst",  64'(pop_inst_o),  64'h00500013);
`else
    chk("nobyp_valid", 64'(pop_valid_o), 64'd0);
`endif
    tick(); idle(1'b1);
    mid();
`ifdef IF_ID_QUEUE_BYPASS_EN
    chk("byp_next_count", 64'(count_o),     64'd0);
    chk("byp_next_valid", 64'(pop_valid_o), 64'd0);
`else
    chk("nobyp_next_valid", 64'(pop_valid_o), 64'd1);
    chk("nobyp_next_inst",  64'(pop_inst_o),  64'h00500013);
    chk("nobyp_next_count", 64'(count_o),     64'd1);
`endif
    tick(); idle();
    mid();
    chk("end_count",   64'(count_o),   64'd0);
    chk("sb_leftover", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
